// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU (33 busy cycles, radix-2) and single-cycle MTHI/MTLO.
// Requests seen while busy, or with reserved op codes, are dropped; the caller stalls on busy.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;

   logic               op_signed;
   logic               op_div;
   logic               div_zero;
   logic               rs_neg;
   logic               rt_neg;
   logic [WIDTH-1:0]   rs_mag;
   logic [WIDTH-1:0]   rt_mag;

   // A zero divisor keeps the raw dividend with no sign fix-up, so the
   // restoring loop itself yields lo = all ones and hi = rs_data.
   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_div    = (op == OP_DIV) || (op == OP_DIVU);
      div_zero  = op_div && (rt_data == '0);
      rs_neg    = op_signed && rs_data[WIDTH-1] && !div_zero;
      rt_neg    = op_signed && rt_data[WIDTH-1];
      rs_mag    = rs_neg ? -rs_data : rs_data;
      rt_mag    = rt_neg ? -rt_data : rt_data;
   end

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_next;

   // acc holds {partial, multiplier} for multiply, {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = div_trial >= {1'b0, opb};
      div_diff  = div_trial[WIDTH-1:0] - opb;
      if (is_div) begin
         acc_next = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      prod_fix = neg_lo ? -acc : acc;
      quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (clk_enable) begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid) begin
                  case (op)
                     OP_MTHI: begin
                        hi   <= rs_data;
                        done <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo   <= rs_data;
                        done <= 1'b1;
                     end
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        acc    <= {{WIDTH{1'b0}}, rs_mag};
                        opb    <= rt_mag;
                        is_div <= op_div;
                        neg_lo <= rs_neg ^ rt_neg;
                        neg_hi <= op_div && rs_neg;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == LAST_STEP) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               count <= '0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed vectors for hilo_muldiv_unit; expectations queued at issue, checked by a done-driven monitor.
module tb_hilo_muldiv_unit;
   localparam int W = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic         clk = 1'b0;
   logic         reset;
   logic         clk_enable;
   logic         op_valid;
   logic [2:0]   op;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .op_valid   (op_valid),
      .op         (op),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           busy_len;
   } exp_t;

   exp_t         sb[$];
   int           n_vec = 0;
   int           n_fail = 0;
   int           busy_run = 0;
   string        cur_name = "reset";
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_name, name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("hi", 64'(hi), 64'(e.hi));
               check("lo", 64'(lo), 64'(e.lo));
               check("busy_cycles", 64'(busy_run), 64'(e.busy_len));
            end
            busy_run = 0;
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      op_valid = 1'b1;
      op       = o;
      rs_data  = a;
      rt_data  = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic expect_result(input logic [W-1:0] ehi, input logic [W-1:0] elo, input int ebusy);
      exp_t e;
      e.hi       = ehi;
      e.lo       = elo;
      e.busy_len = ebusy;
      sb.push_back(e);
   endtask

   task automatic drain();
      int i = 0;
      while (sb.size() != 0 && i < 200) begin
         @(posedge clk);
         i++;
      end
      check("drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input int ebusy);
      cur_name = name;
      expect_result(ehi, elo, ebusy);
      issue(o, a, b);
      if (ebusy > 0) begin
         repeat (10) @(posedge clk);
         #1;
         check("hold_hi", 64'(hi), 64'(model_hi));
         check("hold_lo", 64'(lo), 64'(model_lo));
         check("busy_mid", 64'(busy), 64'd1);
      end
      drain();
      model_hi = ehi;
      model_lo = elo;
   endtask

   initial begin
      reset      = 1'b1;
      clk_enable = 1'b1;
      op_valid   = 1'b0;
      op         = '0;
      rs_data    = '0;
      rt_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b0;

      run_op("mthi_8",      OP_MTHI,  32'd8,        32'd0,        32'h0000_0008, 32'h0000_0000, 0);
      run_op("mtlo",        OP_MTLO,  32'h1234_5678, 32'd0,       32'h0000_0008, 32'h1234_5678, 0);
      run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      run_op("mult_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
      run_op("mult_min2",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33);
      run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("div_7_m2",    OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
      run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
      run_op("divu_by0",    OP_DIVU,  32'd100,      32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 33);
      run_op("div_neg_by0", OP_DIV,   32'hFFFF_FF9C, 32'd0,       32'hFFFF_FF9C, 32'hFFFF_FFFF, 33);
      run_op("divu_max_10", OP_DIVU,  32'hFFFF_FFFF, 32'd10,      32'h0000_0005, 32'h1999_9999, 33);

      // MTLO presented while busy must be dropped
      cur_name = "mtlo_busy";
      expect_result(32'h0, 32'h0000_002A, 33);
      issue(OP_MULTU, 32'd6, 32'd7);
      repeat (3) @(posedge clk);
      issue(OP_MTLO, 32'h0000_DEAD, 32'd0);
      drain();
      model_hi = 32'h0;
      model_lo = 32'h0000_002A;

      cur_name = "reserved";
      issue(3'b110, 32'h1111_1111, 32'h2222_2222);
      issue(3'b111, 32'h3333_3333, 32'h4444_4444);
      repeat (3) @(posedge clk);
      #1;
      check("busy", 64'(busy), 64'd0);
      check("hi", 64'(hi), 64'(model_hi));
      check("lo", 64'(lo), 64'(model_lo));

      // Five disabled cycles mid-CALC stretch busy from 33 to 38
      cur_name = "clk_enable";
      expect_result(32'h0000_000F, 32'h000C_0000, 38);
      issue(OP_MULTU, 32'h0003_0000, 32'h0005_0004);
      repeat (8) @(posedge clk);
      #1;
      clk_enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("frozen_busy", 64'(busy), 64'd1);
      check("frozen_lo", 64'(lo), 64'(model_lo));
      clk_enable = 1'b1;
      drain();
      model_hi = 32'h0000_000F;
      model_lo = 32'h000C_0000;

      // Reset in the middle of a divide: nothing queued, so any done is flagged
      cur_name = "reset_abort";
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("hi", 64'(hi), 64'd0);
      check("lo", 64'(lo), 64'd0);
      check("busy", 64'(busy), 64'd0);
      check("done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      model_hi = '0;
      model_lo = '0;
      repeat (40) @(posedge clk);
      #1;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_lo", 64'(lo), 64'd0);

      run_op("mtlo_after_rst", OP_MTLO, 32'd5, 32'd0, 32'h0, 32'h0000_0005, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
